// File: rtl/alu_if.sv
// Operand/opcode/result bundle between a datapath driver and the alu.
// Master drives the operation, slave returns the registered result and flag.
interface alu_if #(
    parameter int nIO = 8
);
    logic signed [nIO-1:0] A;
    logic signed [nIO-1:0] B;
    logic        [2:0]     OP;
    logic signed [nIO-1:0] Z;
    logic                  OV;

    modport master (output A, B, OP, input  Z, OV);
    modport slave  (input  A, B, OP, output Z, OV);
endinterface

// File: rtl/alu.sv
// Single-cycle signed ALU stage: combinational decode of A/B/OP captured into
// the Z/OV register each rising edge; results wrap, OV flags signed overflow.
module alu #(
    parameter int nIO = 8
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  io
);
    localparam int K = (nIO > 1) ? $clog2(nIO) : 1;
    localparam int MSB = nIO - 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRA = 3'b110,
        OP_SLT = 3'b111
    } op_e;

    logic [K-1:0]          w_sh;
    logic signed [nIO-1:0] w_sum;
    logic signed [nIO-1:0] w_dif;
    logic signed [nIO-1:0] w_sll;
    logic signed [nIO-1:0] w_z;
    logic                  w_ov;
    logic signed [nIO-1:0] r_z;
    logic                  r_ov;

    assign w_sh  = io.B[K-1:0];
    assign w_sum = io.A + io.B;
    assign w_dif = io.A - io.B;
    assign w_sll = io.A << w_sh;

    always_comb begin
        w_z  = '0;
        w_ov = 1'b0;
        case (op_e'(io.OP))
            OP_ADD: begin
                w_z  = w_sum;
                w_ov = (io.A[MSB] == io.B[MSB]) && (w_sum[MSB] != io.A[MSB]);
            end
            OP_SUB: begin
                w_z  = w_dif;
                w_ov = (io.A[MSB] != io.B[MSB]) && (w_dif[MSB] != io.A[MSB]);
            end
            OP_AND: w_z = io.A & io.B;
            OP_OR:  w_z = io.A | io.B;
            OP_XOR: w_z = io.A ^ io.B;
            OP_SLL: begin
                w_z  = w_sll;
                // Shifting back arithmetically recovers A only if no dropped
                // bit or the new sign bit disagreed with A's sign.
                w_ov = ((w_sll >>> w_sh) != io.A);
            end
            OP_SRA: w_z = io.A >>> w_sh;
            OP_SLT: w_z = {{(nIO-1){1'b0}}, (io.A < io.B)};
            default: begin
                w_z  = '0;
                w_ov = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_z  <= '0;
            r_ov <= 1'b0;
        end else begin
            r_z  <= w_z;
            r_ov <= w_ov;
        end
    end

    assign io.Z  = r_z;
    assign io.OV = r_ov;
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu (nIO = 8): directed vector table, reset corners,
// and a randomized sweep against an integer-arithmetic reference model.
module tb_alu;
    localparam int N = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    alu_if #(.nIO(N)) bus ();
    alu #(.nIO(N)) dut (.clk(clk), .rst(rst), .io(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] z;
        logic       ov;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic apply(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.OP = op;
        bus.A  = a;
        bus.B  = b;
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer results, overflow means "outside the 8-bit signed range".
    function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] z, output logic ov);
        longint sa, sb, r, d;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        d  = longint'(1) << b[2:0];
        r  = 0;
        ov = 1'b0;
        case (op)
            3'd0: r = sa + sb;
            3'd1: r = sa - sb;
            3'd2: r = longint'(a & b);
            3'd3: r = longint'(a | b);
            3'd4: r = longint'(a ^ b);
            3'd5: r = sa * d;
            3'd6: r = (sa >= 0) ? sa / d : -((-sa + d - 1) / d);
            default: r = (sa < sb) ? 1 : 0;
        endcase
        if (op == 3'd0 || op == 3'd1 || op == 3'd5)
            ov = (r > 127) || (r < -128);
        z = r[7:0];
    endfunction

    initial begin
        logic [7:0] ez;
        logic       eov;
        logic [2:0] rop;
        logic [7:0] ra, rb;

        total = 0;
        bad   = 0;

        vt[0]  = '{"add_m3_p5",   3'd0, 8'hFD, 8'h05, 8'h02, 1'b0};
        vt[1]  = '{"add_100_50",  3'd0, 8'h64, 8'h32, 8'h96, 1'b1};
        vt[2]  = '{"add_min_m1",  3'd0, 8'h80, 8'hFF, 8'h7F, 1'b1};
        vt[3]  = '{"sub_min_1",   3'd1, 8'h80, 8'h01, 8'h7F, 1'b1};
        vt[4]  = '{"sub_10_20",   3'd1, 8'h0A, 8'h14, 8'hF6, 1'b0};
        vt[5]  = '{"sub_0_min",   3'd1, 8'h00, 8'h80, 8'h80, 1'b1};
        vt[6]  = '{"and",         3'd2, 8'hCA, 8'h3F, 8'h0A, 1'b0};
        vt[7]  = '{"or",          3'd3, 8'hCA, 8'h3F, 8'hFF, 1'b0};
        vt[8]  = '{"xor",         3'd4, 8'hCA, 8'h3F, 8'hF5, 1'b0};
        vt[9]  = '{"sll_21_2",    3'd5, 8'h21, 8'h02, 8'h84, 1'b1};
        vt[10] = '{"sra_84_3",    3'd6, 8'h84, 8'h03, 8'hF0, 1'b0};
        vt[11] = '{"sra_84_0b",   3'd6, 8'h84, 8'h0B, 8'hF0, 1'b0};
        vt[12] = '{"slt_m1_1",    3'd7, 8'hFF, 8'h01, 8'h01, 1'b0};
        vt[13] = '{"slt_5_m5",    3'd7, 8'h05, 8'hFB, 8'h00, 1'b0};

        rst    = 1'b0;
        bus.A  = 8'h11;
        bus.B  = 8'h22;
        bus.OP = 3'd0;
        #1 rst = 1'b1;
        #1;
        chk("reset_z", bus.Z, 8'h00);
        chk("reset_ov", {7'b0, bus.OV}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[i]) begin
            apply(vt[i].op, vt[i].a, vt[i].b);
            chk({vt[i].name, "_z"}, bus.Z, vt[i].z);
            chk({vt[i].name, "_ov"}, {7'b0, bus.OV}, {7'b0, vt[i].ov});
        end

        // Load Z=0x5A, OV=1, then hit reset between edges.
        apply(3'd0, 8'h80, 8'hDA);
        chk("pre_rst_z", bus.Z, 8'h5A);
        chk("pre_rst_ov", {7'b0, bus.OV}, 8'h01);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_z", bus.Z, 8'h00);
        chk("async_rst_ov", {7'b0, bus.OV}, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_rst_z", bus.Z, 8'h00);
        chk("hold_rst_ov", {7'b0, bus.OV}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rel_z", bus.Z, 8'h00);
        @(posedge clk);
        #1;
        chk("first_cap_z", bus.Z, 8'h5A);
        chk("first_cap_ov", {7'b0, bus.OV}, 8'h01);

        for (int n = 0; n < 1000; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            model(rop, ra, rb, ez, eov);
            apply(rop, ra, rb);
            chk($sformatf("rnd%0d_op%0d_%02h_%02h_z", n, rop, ra, rb), bus.Z, ez);
            chk($sformatf("rnd%0d_op%0d_%02h_%02h_ov", n, rop, ra, rb), {7'b0, bus.OV}, {7'b0, eov});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
